// File: rtl/traffic_phase_controller.sv
// Actuated N-phase intersection controller: per phase GREEN -> YELLOW ->
// ALL_RED, then round-robin to the next phase with latched demand.
// Optional build macro FLASH_MODE_EN adds i_flash_req and flashing yellow.
// Ports: clk, reset (sync, active-high), i_enable, i_demand[N],
//  i_green_time[N*TIME_W], i_yellow_time, i_all_red_time,
//  o_red/o_yellow/o_green[N], o_active_phase, o_pending[N], o_cycle_done.
module traffic_phase_controller #(
  parameter int NUM_PHASES = 4,
  parameter int TIME_W     = 8,
  parameter int FLASH_HALF = 50
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_enable,
  input  logic [NUM_PHASES-1:0]        i_demand,
  input  logic [NUM_PHASES*TIME_W-1:0] i_green_time,
  input  logic [TIME_W-1:0]            i_yellow_time,
  input  logic [TIME_W-1:0]            i_all_red_time,
`ifdef FLASH_MODE_EN
  input  logic                         i_flash_req,
`endif
  output logic [NUM_PHASES-1:0]        o_red,
  output logic [NUM_PHASES-1:0]        o_yellow,
  output logic [NUM_PHASES-1:0]        o_green,
  output logic [$clog2(NUM_PHASES)-1:0] o_active_phase,
  output logic [NUM_PHASES-1:0]        o_pending,
  output logic                         o_cycle_done
);

  localparam int PW = $clog2(NUM_PHASES);

  typedef enum logic [1:0] {
    S_ALL_RED,
    S_GREEN,
    S_YELLOW,
    S_FLASH
  } state_t;

  // Elaboration-time range guard; intentionally empty.
  if (NUM_PHASES < 2 || NUM_PHASES > 8 || FLASH_HALF < 1) begin : g_bad_params
  end

  state_t                r_state, w_state_n;
  logic [TIME_W-1:0]     r_cnt, w_cnt_n;
  logic [PW-1:0]         r_phase, w_phase_n;
  logic [NUM_PHASES-1:0] r_pending;
  logic [NUM_PHASES-1:0] w_clr;
  logic                  w_cycle_done;
  logic                  w_found;
  logic [PW-1:0]         w_q;
  logic [TIME_W-1:0]     w_gt [NUM_PHASES];

`ifdef FLASH_MODE_EN
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam logic [FW-1:0] FL_LD = FW'(FLASH_HALF - 1);
  logic [FW-1:0] r_fcnt, w_fcnt_n;
  logic          r_fon, w_fon_n;
`endif

  // Interval of length T runs T cycles; T=0 behaves as 1.
  function automatic logic [TIME_W-1:0] f_ld(input logic [TIME_W-1:0] t);
    return (t == '0) ? '0 : t - TIME_W'(1);
  endfunction

  for (genvar p = 0; p < NUM_PHASES; p++) begin : g_gt
    assign w_gt[p] = i_green_time[p*TIME_W +: TIME_W];
  end

  // First pending phase in order p+1 .. p+N (p itself comes last).
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx   = '0;
    w_found = 1'b0;
    w_q     = r_phase;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      v_idx = PW'((int'(r_phase) + k) % NUM_PHASES);
      if (r_pending[v_idx]) begin
        w_found = 1'b1;
        w_q     = v_idx;
      end
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_phase_n    = r_phase;
    w_clr        = '0;
    w_cycle_done = 1'b0;
`ifdef FLASH_MODE_EN
    w_fcnt_n     = r_fcnt;
    w_fon_n      = r_fon;
    if (i_flash_req) begin
      w_state_n = S_FLASH;
      if (r_state != S_FLASH) begin
        w_fon_n  = 1'b1;
        w_fcnt_n = FL_LD;
      end else if (r_fcnt == '0) begin
        w_fon_n  = ~r_fon;
        w_fcnt_n = FL_LD;
      end else begin
        w_fcnt_n = r_fcnt - FW'(1);
      end
    end else if (r_state == S_FLASH) begin
      w_state_n = S_ALL_RED;
      w_cnt_n   = f_ld(i_all_red_time);
    end else
`endif
    if (i_enable) begin
      unique case (r_state)
        S_GREEN: begin
          if (r_cnt != '0) begin
            w_cnt_n = r_cnt - TIME_W'(1);
          end else begin
            w_state_n = S_YELLOW;
            w_cnt_n   = f_ld(i_yellow_time);
          end
        end
        S_YELLOW: begin
          if (r_cnt != '0) begin
            w_cnt_n = r_cnt - TIME_W'(1);
          end else begin
            w_state_n = S_ALL_RED;
            w_cnt_n   = f_ld(i_all_red_time);
          end
        end
        S_ALL_RED: begin
          // Counter parks at 0 while resting; search repeats each cycle.
          if (r_cnt != '0) begin
            w_cnt_n = r_cnt - TIME_W'(1);
          end else if (w_found) begin
            w_state_n    = S_GREEN;
            w_phase_n    = w_q;
            w_cnt_n      = f_ld(w_gt[w_q]);
            w_clr[w_q]   = 1'b1;
            w_cycle_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_ALL_RED;
      r_cnt     <= f_ld(i_all_red_time);
      r_phase   <= '0;
      r_pending <= '0;
`ifdef FLASH_MODE_EN
      r_fcnt    <= '0;
      r_fon     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_phase   <= w_phase_n;
      r_pending <= (r_pending | i_demand) & ~w_clr;
`ifdef FLASH_MODE_EN
      r_fcnt    <= w_fcnt_n;
      r_fon     <= w_fon_n;
`endif
    end
  end

  always_comb begin
    o_red    = '1;
    o_yellow = '0;
    o_green  = '0;
    unique case (r_state)
      S_GREEN: begin
        o_red[r_phase]   = 1'b0;
        o_green[r_phase] = 1'b1;
      end
      S_YELLOW: begin
        o_red[r_phase]    = 1'b0;
        o_yellow[r_phase] = 1'b1;
      end
`ifdef FLASH_MODE_EN
      S_FLASH: begin
        o_red    = '0;
        o_yellow = {NUM_PHASES{r_fon}};
      end
`endif
      default: ;
    endcase
  end

  assign o_active_phase = r_phase;
  assign o_pending      = r_pending;
  assign o_cycle_done   = w_cycle_done;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed self-checking bench for traffic_phase_controller.
// Walks the phase sequence, timing edge cases, enable/reset and flash.
`timescale 1ns/1ps
module tb_traffic_phase_controller;

  localparam int N  = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_enable = 1'b1;
  logic [N-1:0]  i_demand = '0;
  logic [N*TW-1:0] i_green_time = {8'd5, 8'd5, 8'd5, 8'd5};
  logic [TW-1:0] i_yellow_time = 8'd3;
  logic [TW-1:0] i_all_red_time = 8'd2;
`ifdef FLASH_MODE_EN
  logic          i_flash_req = 1'b0;
`endif
  logic [N-1:0]  o_red, o_yellow, o_green, o_pending;
  logic [1:0]    o_active_phase;
  logic          o_cycle_done;

  traffic_phase_controller #(
    .NUM_PHASES(N), .TIME_W(TW), .FLASH_HALF(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_enable(i_enable),
    .i_demand(i_demand),
    .i_green_time(i_green_time),
    .i_yellow_time(i_yellow_time),
    .i_all_red_time(i_all_red_time),
`ifdef FLASH_MODE_EN
    .i_flash_req(i_flash_req),
`endif
    .o_red(o_red),
    .o_yellow(o_yellow),
    .o_green(o_green),
    .o_active_phase(o_active_phase),
    .o_pending(o_pending),
    .o_cycle_done(o_cycle_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] d);
    i_demand = d;
    step();
    i_demand = '0;
  endtask

  task automatic wait_cd(input string tag);
    int n = 0;
    while (o_cycle_done !== 1'b1 && n < 200) begin
      n++;
      step();
    end
    check(tag, o_cycle_done, 1'b1);
  endtask

  // ar=50 means the controller rests in ALL_RED (bound reached).
  task automatic serve(input string t, input int p, input int g,
                       input int y, input int ar);
    int n;
    logic [N-1:0] m;
    m = 4'(1 << p);
    wait_cd({t, "_cd"});
    step();
    check({t, "_gphase"}, o_green, m);
    check({t, "_active"}, o_active_phase, p);
    n = 0;
    while (o_green == m && n < 100) begin n++; step(); end
    check({t, "_glen"}, n, g);
    n = 0;
    while (o_yellow == m && n < 100) begin n++; step(); end
    check({t, "_ylen"}, n, y);
    n = 0;
    while (o_red == 4'hF && !o_cycle_done && n < 50) begin
      n++;
      step();
    end
    if (o_cycle_done) n++;
    check({t, "_arlen"}, n, ar);
  endtask

  // Lamp safety monitor.
  logic [N-1:0] pr, pg;
  always @(negedge clk) begin
    if (!reset && o_red != '0) begin
      logic ok;
      ok = ($countones(~o_red) <= 1);
      for (int p = 0; p < N; p++)
        if (int'(o_red[p]) + int'(o_yellow[p]) + int'(o_green[p]) != 1)
          ok = 1'b0;
      check("lamp_safe", ok, 1'b1);
    end
    if (!reset && o_green != '0 && pg == '0)
      check("green_after_allred", pr, 4'hF);
    pr = o_red;
    pg = o_green;
  end

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    step(); step(); step();
    check("rst_red", o_red, 4'hF);
    check("rst_yel", o_yellow, 4'h0);
    check("rst_grn", o_green, 4'h0);
    check("rst_cd", o_cycle_done, 1'b0);
    check("rst_pend", o_pending, 4'h0);
    check("rst_act", o_active_phase, 0);
    reset = 1'b0;
    repeat (4) step();

    // 1: full round 1,2,3,0
    pulse(4'hF);
    check("t1_pend", o_pending, 4'hF);
    serve("t1p1", 1, 5, 3, 2);
    serve("t1p2", 2, 5, 3, 2);
    serve("t1p3", 3, 5, 3, 2);
    serve("t1p0", 0, 5, 3, 50);

    // 2: single demand, then rest
    pulse(4'b0100);
    serve("t2", 2, 5, 3, 50);
    check("t2_red", o_red, 4'hF);
    check("t2_grn", o_green, 4'h0);
    check("t2_pend", o_pending, 4'h0);

    // 3: zero times act as one cycle; mid-green change ignored
    i_green_time[15:8] = 8'd0;
    i_yellow_time = 8'd0;
    pulse(4'b0010);
    serve("t3", 1, 1, 1, 50);
    pulse(4'b0100);
    wait_cd("t3b_cd");
    step();
    check("t3b_g", o_green, 4'b0100);
    i_green_time[23:16] = 8'd1;
    n = 0;
    while (o_green == 4'b0100 && n < 50) begin n++; step(); end
    check("t3b_glen", n, 5);
    i_green_time[23:16] = 8'd5;
    i_green_time[15:8] = 8'd5;
    i_yellow_time = 8'd3;
    repeat (6) step();

    // 4: demand absorbed on entry, re-latched during yellow
    pulse(4'b1000);
    wait_cd("t4_cd");
    pulse(4'b1000);
    check("t4_grn", o_green, 4'b1000);
    check("t4_absorb", o_pending, 4'h0);
    n = 0;
    while (o_green == 4'b1000 && n < 50) begin n++; step(); end
    check("t4_glen", n, 5);
    check("t4_yel", o_yellow, 4'b1000);
    pulse(4'b1000);
    check("t4_relatch", o_pending, 4'b1000);
    serve("t4b", 3, 5, 3, 50);

    // 5: enable low 7 cycles stretches green; reset mid-yellow
    pulse(4'b0001);
    wait_cd("t5_cd");
    step();
    check("t5_grn", o_green, 4'b0001);
    n = 0;
    while (o_green == 4'b0001 && n < 50) begin
      n++;
      if (n == 2) i_enable = 1'b0;
      if (n == 9) i_enable = 1'b1;
      step();
    end
    check("t5_glen", n, 12);
    check("t5_yel", o_yellow, 4'b0001);
    pulse(4'b0110);
    check("t5_pend", o_pending, 4'b0110);
    check("t5_yel2", o_yellow, 4'b0001);
    reset = 1'b1;
    step();
    check("t5_rst_red", o_red, 4'hF);
    check("t5_rst_yel", o_yellow, 4'h0);
    check("t5_rst_pend", o_pending, 4'h0);
    check("t5_rst_act", o_active_phase, 0);
    reset = 1'b0;
    step();

`ifdef FLASH_MODE_EN
    // 6: flash during green(2), release resumes search after phase 2
    pulse(4'b0100);
    wait_cd("t6_cd");
    step();
    check("t6_grn", o_green, 4'b0100);
    step();
    i_flash_req = 1'b1;
    i_demand = 4'b0101;
    step();
    i_demand = '0;
    for (int i = 0; i < 8; i++) begin
      check("t6_fyel", o_yellow, (i < 4) ? 4'hF : 4'h0);
      check("t6_fred", o_red, 4'h0);
      step();
    end
    check("t6_pend", o_pending, 4'b0101);
    check("t6_act", o_active_phase, 2);
    i_flash_req = 1'b0;
    step();
    n = 0;
    while (o_red == 4'hF && !o_cycle_done && n < 50) begin
      n++;
      step();
    end
    if (o_cycle_done) n++;
    check("t6_arlen", n, 2);
    step();
    check("t6_next", o_green, 4'b0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
